// File: rtl/hazard_scoreboard_unit_if.sv
// Hazard controller bundle: datapath-side status in, stage stall/flush and
// forwarding selects out. The datapath drives through master; the hazard
// unit attaches through slave.
interface hazard_scoreboard_unit_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic              InstrMissF;
    logic              DataMissM;
    logic [REG_AW-1:0] Rs1D;
    logic [REG_AW-1:0] Rs2D;
    logic [REG_AW-1:0] RdD;
    logic              LongOpD;
    logic [REG_AW-1:0] Rs1E;
    logic [REG_AW-1:0] Rs2E;
    logic [REG_AW-1:0] RdE;
    logic              ResultSrcEb2;
    logic              LongStartE;
    logic              PCSrcb1;
    logic [1:0]        PCSrcReg;
    logic [REG_AW-1:0] RdM;
    logic              RegWriteM;
    logic [REG_AW-1:0] RdW;
    logic              RegWriteW;
    logic              LongDoneW;
    logic              StallCntClr;
    logic              StallF;
    logic              StallD;
    logic              StallE;
    logic              StallM;
    logic              StallW;
    logic              FlushD;
    logic              FlushE;
    logic [1:0]        ForwardAE;
    logic [1:0]        ForwardBE;
    logic              LongBusy;
    logic [CNT_W-1:0]  StallCount;

    modport master (
        output InstrMissF, DataMissM, Rs1D, Rs2D, RdD, LongOpD,
               Rs1E, Rs2E, RdE, ResultSrcEb2, LongStartE, PCSrcb1, PCSrcReg,
               RdM, RegWriteM, RdW, RegWriteW, LongDoneW, StallCntClr,
        input  StallF, StallD, StallE, StallM, StallW, FlushD, FlushE,
               ForwardAE, ForwardBE, LongBusy, StallCount
    );

    modport slave (
        input  InstrMissF, DataMissM, Rs1D, Rs2D, RdD, LongOpD,
               Rs1E, Rs2E, RdE, ResultSrcEb2, LongStartE, PCSrcb1, PCSrcReg,
               RdM, RegWriteM, RdW, RegWriteW, LongDoneW, StallCntClr,
        output StallF, StallD, StallE, StallM, StallW, FlushD, FlushE,
               ForwardAE, ForwardBE, LongBusy, StallCount
    );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// Five-stage pipeline hazard controller: E-stage forwarding, load-use and
// long-unit scoreboard stalls, cache-miss freeze and a saturating stall counter.
module hazard_scoreboard_unit #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input logic clk,
    input logic reset_n,
    hazard_scoreboard_unit_if.slave hz
);
    localparam int Depth = 2 ** REG_AW;

    logic [Depth-1:0] pend;
    logic             longBusy;
    logic [CNT_W-1:0] stallCount;

    logic freeze;
    logic startAcc;
    logic busyStart;
    logic doneAcc;
    logic loadStall;
    logic sbStall;
    logic structStall;
    logic dStall;
    logic unusedPcSrc;

    // Pending bit as seen by D, with a retiring write releasing it this cycle.
    function automatic logic effPend(input logic [REG_AW-1:0] r);
        return pend[r] & ~(doneAcc & (hz.RdW == r));
    endfunction

    // M beats W; register zero is never forwarded.
    function automatic logic [1:0] fwdSel(input logic [REG_AW-1:0] src);
        if (src != '0 && hz.RegWriteM && src == hz.RdM)
            return 2'b10;
        else if (src != '0 && hz.RegWriteW && src == hz.RdW)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    // Hazard terms; starts and retires are masked while their stage is frozen.
    always_comb begin
        freeze      = hz.InstrMissF | hz.DataMissM;
        busyStart   = hz.LongStartE & ~freeze;
        startAcc    = busyStart & (hz.RdE != '0);
        doneAcc     = hz.LongDoneW & ~freeze;
        loadStall   = hz.ResultSrcEb2 & (hz.RdE != '0) &
                      ((hz.Rs1D == hz.RdE) | (hz.Rs2D == hz.RdE));
        sbStall     = effPend(hz.Rs1D) | effPend(hz.Rs2D) | effPend(hz.RdD);
        structStall = hz.LongOpD & (longBusy | hz.LongStartE) & ~doneAcc;
        dStall      = loadStall | sbStall | structStall;
        unusedPcSrc = hz.PCSrcReg[0];
    end

    // Stage controls, forwarding selects and state visibility.
    always_comb begin
        hz.StallF     = (dStall | freeze) & ~hz.PCSrcReg[1];
        hz.StallD     = dStall | freeze;
        hz.StallE     = freeze;
        hz.StallM     = freeze;
        hz.StallW     = freeze;
        hz.FlushD     = hz.PCSrcb1 & ~freeze;
        hz.FlushE     = (hz.PCSrcb1 | dStall) & ~freeze;
        hz.ForwardAE  = fwdSel(hz.Rs1E);
        hz.ForwardBE  = fwdSel(hz.Rs2E);
        hz.LongBusy   = longBusy;
        hz.StallCount = stallCount;
    end

    // Scoreboard: clear then set, so a same-index start overrides the retire.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend <= '0;
        end else begin
            if (doneAcc)
                pend[hz.RdW] <= 1'b0;
            if (startAcc)
                pend[hz.RdE] <= 1'b1;
            pend[0] <= 1'b0;
        end
    end

    // Long-unit occupancy; a start in the retire cycle keeps it busy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            longBusy <= 1'b0;
        else if (busyStart)
            longBusy <= 1'b1;
        else if (doneAcc)
            longBusy <= 1'b0;
    end

    // Saturating count of cycles in which D is held; clear has priority.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            stallCount <= '0;
        else if (hz.StallCntClr)
            stallCount <= '0;
        else if ((dStall | freeze) && stallCount != '1)
            stallCount <= stallCount + 1'b1;
    end
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit with a 4-bit stall counter.
module tb_hazard_scoreboard_unit;
    logic clk;
    logic reset_n;
    int   compared;
    int   mismatched;

    hazard_scoreboard_unit_if #(.REG_AW(5), .CNT_W(4)) hzIf ();

    hazard_scoreboard_unit #(.REG_AW(5), .CNT_W(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .hz      (hzIf.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("mismatch at %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        hzIf.InstrMissF = 0; hzIf.DataMissM = 0;
        hzIf.Rs1D = 0; hzIf.Rs2D = 0; hzIf.RdD = 0; hzIf.LongOpD = 0;
        hzIf.Rs1E = 0; hzIf.Rs2E = 0; hzIf.RdE = 0;
        hzIf.ResultSrcEb2 = 0; hzIf.LongStartE = 0;
        hzIf.PCSrcb1 = 0; hzIf.PCSrcReg = 0;
        hzIf.RdM = 0; hzIf.RegWriteM = 0; hzIf.RdW = 0; hzIf.RegWriteW = 0;
        hzIf.LongDoneW = 0; hzIf.StallCntClr = 0;
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        reset_n = 1'b0;
        idle();
        #2;
        chk("rst_busy", hzIf.LongBusy, 0);
        chk("rst_count", hzIf.StallCount, 0);
        chk("rst_stalls", {hzIf.StallF, hzIf.StallD, hzIf.StallE, hzIf.StallM, hzIf.StallW}, 0);
        chk("rst_flush", {hzIf.FlushD, hzIf.FlushE}, 0);
        chk("rst_fwd", {hzIf.ForwardAE, hzIf.ForwardBE}, 0);
        #10 reset_n = 1'b1;
        tick();

        // Forwarding
        hzIf.Rs1E = 5; hzIf.RdM = 5; hzIf.RegWriteM = 1; hzIf.RdW = 5; hzIf.RegWriteW = 1;
        #1 chk("fwd_m_prio", hzIf.ForwardAE, 2'b10);
        chk("fwd_b_none", hzIf.ForwardBE, 2'b00);
        hzIf.RdM = 6;
        #1 chk("fwd_w", hzIf.ForwardAE, 2'b01);
        hzIf.Rs2E = 6;
        #1 chk("fwd_b_m", hzIf.ForwardBE, 2'b10);
        hzIf.Rs1E = 0;
        #1 chk("fwd_zero", hzIf.ForwardAE, 2'b00);
        hzIf.Rs1E = 6; hzIf.RegWriteM = 0; hzIf.RdW = 6;
        #1 chk("fwd_m_nowe", hzIf.ForwardAE, 2'b01);
        idle();

        // Load-use
        hzIf.ResultSrcEb2 = 1; hzIf.RdE = 0; hzIf.Rs2D = 0;
        #1 chk("load_x0", hzIf.StallD, 0);
        hzIf.RdE = 7; hzIf.Rs2D = 7;
        #1 chk("load_stall", {hzIf.StallF, hzIf.StallD, hzIf.FlushE, hzIf.FlushD, hzIf.StallE}, 5'b11100);
        tick();
        chk("load_count", hzIf.StallCount, 1);
        idle();
        hzIf.StallCntClr = 1;
        tick();
        chk("clr_count", hzIf.StallCount, 0);
        hzIf.StallCntClr = 0;

        // Scoreboard RAW
        hzIf.LongStartE = 1; hzIf.RdE = 9;
        #1 chk("sb_busy_pre", hzIf.LongBusy, 0);
        tick();
        hzIf.LongStartE = 0; hzIf.RdE = 0;
        chk("sb_busy", hzIf.LongBusy, 1);
        hzIf.Rs1D = 9;
        #1 chk("sb_raw0", {hzIf.StallD, hzIf.FlushE}, 2'b11);
        tick();
        chk("sb_raw1", hzIf.StallD, 1);
        tick();
        chk("sb_raw2", hzIf.StallD, 1);
        tick();
        hzIf.LongDoneW = 1; hzIf.RdW = 9; hzIf.RegWriteW = 1;
        #1 chk("sb_bypass", hzIf.StallD, 0);
        tick();
        hzIf.LongDoneW = 0; hzIf.RegWriteW = 0; hzIf.RdW = 0;
        #1 chk("sb_cleared", hzIf.StallD, 0);
        chk("sb_busy_done", hzIf.LongBusy, 0);
        chk("sb_count", hzIf.StallCount, 3);
        idle();

        // Structural / WAW
        hzIf.LongStartE = 1; hzIf.RdE = 9;
        tick();
        idle();
        hzIf.LongOpD = 1; hzIf.RdD = 3;
        #1 chk("struct", hzIf.StallD, 1);
        hzIf.LongOpD = 0; hzIf.RdD = 9;
        #1 chk("waw", hzIf.StallD, 1);
        hzIf.RdD = 0;
        #1 chk("waw_none", hzIf.StallD, 0);
        hzIf.LongDoneW = 1; hzIf.RdW = 9; hzIf.LongStartE = 1; hzIf.RdE = 10; hzIf.LongOpD = 1;
        #1 chk("struct_bypass", hzIf.StallD, 0);
        tick();
        idle();
        chk("busy_overlap", hzIf.LongBusy, 1);
        hzIf.Rs1D = 10;
        #1 chk("pend10", hzIf.StallD, 1);
        hzIf.Rs1D = 9;
        #1 chk("pend9_clr", hzIf.StallD, 0);
        hzIf.Rs1D = 0;
        hzIf.LongDoneW = 1; hzIf.RdW = 10; hzIf.LongStartE = 1; hzIf.RdE = 10;
        tick();
        idle();
        hzIf.Rs1D = 10;
        #1 chk("set_wins", hzIf.StallD, 1);
        hzIf.Rs1D = 0;
        hzIf.LongDoneW = 1; hzIf.RdW = 10;
        tick();
        idle();
        hzIf.Rs1D = 10;
        #1 chk("retire10", {hzIf.StallD, hzIf.LongBusy}, 2'b00);
        idle();

        // Freeze and redirect
        hzIf.DataMissM = 1; hzIf.PCSrcb1 = 1;
        #1 chk("frz_stalls", {hzIf.StallF, hzIf.StallD, hzIf.StallE, hzIf.StallM, hzIf.StallW}, 5'b11111);
        chk("frz_flush", {hzIf.FlushD, hzIf.FlushE}, 2'b00);
        hzIf.DataMissM = 0;
        #1 chk("redir_flush", {hzIf.FlushD, hzIf.FlushE, hzIf.StallF, hzIf.StallD}, 4'b1100);
        hzIf.PCSrcb1 = 0; hzIf.InstrMissF = 1; hzIf.PCSrcReg = 2'b10;
        #1 chk("pcsrcreg", {hzIf.StallF, hzIf.StallD}, 2'b01);
        hzIf.PCSrcReg = 0; hzIf.LongStartE = 1; hzIf.RdE = 12;
        tick();
        idle();
        hzIf.Rs1D = 12;
        #1 chk("frz_mask", {hzIf.LongBusy, hzIf.StallD}, 2'b00);
        idle();

        // Counter saturation
        hzIf.StallCntClr = 1;
        tick();
        chk("cnt_clr", hzIf.StallCount, 0);
        hzIf.StallCntClr = 0;
        hzIf.DataMissM = 1;
        for (int i = 0; i < 14; i++) tick();
        chk("cnt_14", hzIf.StallCount, 14);
        tick();
        chk("cnt_15", hzIf.StallCount, 15);
        tick();
        chk("cnt_sat", hzIf.StallCount, 15);
        hzIf.StallCntClr = 1;
        tick();
        chk("cnt_clr_prio", hzIf.StallCount, 0);
        idle();

        // Async reset mid long op
        hzIf.LongStartE = 1; hzIf.RdE = 9;
        tick();
        idle();
        chk("pre_rst_busy", hzIf.LongBusy, 1);
        hzIf.Rs1D = 9;
        #2 reset_n = 1'b0;
        #1 chk("async_busy", hzIf.LongBusy, 0);
        chk("async_pend", hzIf.StallD, 0);
        #10 reset_n = 1'b1;
        tick();
        chk("post_rst", {hzIf.LongBusy, hzIf.StallD}, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard_unit.md
# hazard_scoreboard_unit

Parametrised pipeline hazard controller for the five-stage core, extending combinational forwarding and load-use detection with a per-register pending-write scoreboard. The scoreboard serves a single, non-pipelined, variable-latency long unit (mul/div). The block adds D-cache miss freezing and a saturating stall-cycle performance counter. It sits beside the datapath and drives all stage stall/flush enables and the E-stage forwarding muxes.

## Interface

Parameters:
- `REG_AW`, default 5, register address width; scoreboard depth is 2**`REG_AW`.
- `CNT_W`, default 32, stall counter width.

Ports, with clock and reset first:
- `clk`, input, 1: clock.
- `reset_n`, input, 1: asynchronous active-low reset.
- `InstrMissF`, input, 1: I-cache miss.
- `DataMissM`, input, 1: D-cache miss.
- `Rs1D`, `Rs2D`, `RdD`, input, `REG_AW`: decode operand and destination addresses.
- `LongOpD`, input, 1: the instruction in D targets the long unit.
- `Rs1E`, `Rs2E`, `RdE`, input, `REG_AW`: execute addresses.
- `ResultSrcEb2`, input, 1: load in E.
- `LongStartE`, input, 1: a long op in E is issuing.
- `PCSrcb1`, input, 1: redirect resolved in E.
- `PCSrcReg`, input, 2: registered PC source; bit 1 means a redirect is in flight.
- `RdM`, input, `REG_AW`, and `RegWriteM`, input, 1: M-stage destination and write enable.
- `RdW`, input, `REG_AW`, and `RegWriteW`, input, 1: W-stage destination and write enable.
- `LongDoneW`, input, 1: long result is writing back this cycle to `RdW`.
- `StallCntClr`, input, 1: synchronous clear of `StallCount`.
- `StallF`, `StallD`, `StallE`, `StallM`, `StallW`, output, 1 each: stage holds.
- `FlushD`, `FlushE`, output, 1 each: bubble insertion.
- `ForwardAE`, `ForwardBE`, output, 2 each: 00 none, 01 W, 10 M.
- `LongBusy`, output, 1: the long unit is occupied.
- `StallCount`, output, `CNT_W`: saturating count of frozen or stalled cycles.

## Operation

- **Forwarding** (combinational) for `Rs1E` and, identically, `Rs2E`:
  - Select M (10) if the source equals `RdM`, `RegWriteM` is set, and the source is nonzero.
  - Otherwise select W (01) under the same conditions against `RdW`/`RegWriteW`.
  - Otherwise 00. M has priority.
- **Scoreboard** `pend[2**REG_AW-1:0]`:
  - Set: `pend[RdE]` sets on `LongStartE & ~StallE & RdE!=0`.
  - Clear: `pend[RdW]` clears on `LongDoneW & ~StallW`.
  - Set and clear in the same cycle on the same index: the set wins.
  - `pend[0]` is constant 0.
- **Effective pending:** `eff(r) = pend[r] & ~(LongDoneW & ~StallW & RdW==r)`. A retiring write releases its dependent in the same cycle.
- **Busy flag:**
  - `LongBusy` sets on an accepted `LongStartE`.
  - It clears on an accepted `LongDoneW`.
  - If both occur in the same cycle, `LongBusy` stays 1.
- **Hazard terms:**
  - `LoadStall` = `ResultSrcEb2 & RdE!=0 & (Rs1D==RdE | Rs2D==RdE)`.
  - `SbStall` = `eff(Rs1D) | eff(Rs2D) | eff(RdD)`. The `RdD` term covers WAW.
  - `StructStall` = `LongOpD & (LongBusy | LongStartE) & ~(LongDoneW & ~StallW)`.
  - `DStall` = `LoadStall | SbStall | StructStall`.
  - `Freeze` = `InstrMissF | DataMissM`.
- **Outputs:**
  - `StallF` = `(DStall | Freeze) & ~PCSrcReg[1]`.
  - `StallD` = `DStall | Freeze`.
  - `StallE`, `StallM`, `StallW` = `Freeze`.
  - `FlushD` = `PCSrcb1 & ~Freeze`.
  - `FlushE` = `(PCSrcb1 | DStall) & ~Freeze`.
- **Counter:**
  - `StallCount` increments by 1 each cycle in which `StallD` is 1.
  - It saturates at all-ones.
  - `StallCntClr` has priority over increment.

## Timing

- Reset (async, `reset_n` = 0): `pend` = 0, `LongBusy` = 0, `StallCount` = 0. All combinational outputs follow from the cleared state; with idle inputs they are all 0.
- Deassertion of reset is synchronous to `clk`; the first update happens on the first rising edge with `reset_n` = 1.
- Scoreboard and busy updates take effect on the rising edge after the qualifying cycle.
- A dependent in D is checked against state that includes the same-cycle retire bypass. Its minimum distance from `LongStartE` is therefore the long-unit latency plus 0 extra cycles.
- During `Freeze`, state holds: starts and retires are masked by `StallE`/`StallW`. The counter still counts.
- Reset asserted mid-operation discards all pending bits immediately. The pipeline must be flushed externally.

## Test plan

- **Forwarding:** `Rs1E=5`, `RdM=5`, `RegWriteM=1`, `RdW=5`, `RegWriteW=1` -> `ForwardAE=10`. Setting `RdM=6` -> `ForwardAE=01`. Setting `Rs1E=0` -> `ForwardAE=00`.
- **Load-use:** `ResultSrcEb2=1`, `RdE=7`, `Rs2D=7` -> `StallF=StallD=FlushE=1`, `FlushD=0`. After one cycle `StallCount=1`.
- **Scoreboard RAW:** `LongStartE` with `RdE=9`, then `Rs1D=9` held -> `StallD=1` for each cycle until `LongDoneW=1` with `RdW=9`. That cycle `StallD=0`, and `pend[9]=0` after the edge.
- **Structural / WAW:** while `LongBusy=1`, `LongOpD=1` -> stall. With `RdD=9` and `pend[9]=1` (non-long op) -> stall. A retire and new start in the same cycle -> `LongBusy` remains 1.
- **Freeze and redirect:** `DataMissM=1` with `PCSrcb1=1` -> all five stalls 1, `FlushD=FlushE=0`. Releasing the miss -> `FlushD=FlushE=1`. With `PCSrcReg[1]=1`, `StallF=0`.
- **Reset and counter:** drive `StallD` high for 2**`CNT_W` cycles (`CNT_W=4`) -> `StallCount` saturates at 15. `StallCntClr` -> 0. Async `reset_n` low mid-long-op -> `LongBusy=0` and `pend` cleared immediately.
